conv2_window_buf: RTL and testbench

//  Producer side of the conv2 window interface. Accepts a raster stream of 3-channel

---
 rtl/conv2_pkg.sv | 20 ++
 rtl/conv2_line_shift.sv | 29 ++
 rtl/conv2_window_buf.sv | 64 ++++++
 tb/tb_conv2_window_buf.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_pkg.sv
// Shared geometry for the conv2 window buffer: map size, kernel size and
// the mapping from window element to shift-register tap.
package conv2_pkg;

  localparam int WIDTH  = 12;
  localparam int IMG_W  = 12;
  localparam int IMG_H  = 12;
  localparam int K      = 5;
  localparam int SR_LEN = (K-1)*IMG_W + K;
  localparam int SR_W   = $clog2(SR_LEN);
  localparam int WIN_W  = K*K*WIDTH;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);

  // Element k = r*K + c (row-major, element 0 oldest); stage 0 is the newest sample.
  function automatic int tap_idx(input int k);
    return (K-1-k/K)*IMG_W + (K-1-k%K);
  endfunction

endpackage

// File: rtl/conv2_line_shift.sv
// One channel of the window buffer: SR_LEN-stage shift register that advances
// on each accepted pixel, with the K*K window taps packed onto one bus.
module conv2_line_shift
  import conv2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIN_W-1:0] o_win
);

  logic [WIDTH-1:0] r_sr [SR_LEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SR_LEN; i++) r_sr[i] <= '0;
    end else if (i_en) begin
      r_sr[0] <= i_data;
      for (int i = 1; i < SR_LEN; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  for (genvar k = 0; k < K*K; k++) begin : g_tap
    localparam int unsigned TAP = tap_idx(k);
    assign o_win[k*WIDTH +: WIDTH] = r_sr[TAP[SR_W-1:0]];
  end

endmodule

// File: rtl/conv2_window_buf.sv
// Raster-to-window converter feeding the conv2 channel calculators: three
// channel shift registers plus the col/row tracking that qualifies each window.
module conv2_window_buf
  import conv2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  output logic [WIN_W-1:0] data_out1,
  output logic [WIN_W-1:0] data_out2,
  output logic [WIN_W-1:0] data_out3,
  output logic             valid_out_buf,
  output logic             frame_done
);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_valid;
  logic          r_frame_done;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_in_window;

  assign w_col_last  = (r_col == CW'(IMG_W-1));
  assign w_row_last  = (r_row == RW'(IMG_H-1));
  // Windows only once K-1 rows and K-1 columns of the current frame are in,
  // which also keeps stale samples from the previous frame hidden.
  assign w_in_window = (r_row >= RW'(K-1)) && (r_col >= CW'(K-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid      <= valid_in && w_in_window;
      r_frame_done <= valid_in && w_row_last && w_col_last;
    end
  end

  assign valid_out_buf = r_valid;
  assign frame_done    = r_frame_done;

  conv2_line_shift u_ch1 (.clk(clk), .rst_n(rst_n), .i_en(valid_in), .i_data(data_in1), .o_win(data_out1));
  conv2_line_shift u_ch2 (.clk(clk), .rst_n(rst_n), .i_en(valid_in), .i_data(data_in2), .o_win(data_out2));
  conv2_line_shift u_ch3 (.clk(clk), .rst_n(rst_n), .i_en(valid_in), .i_data(data_in3), .o_win(data_out3));

endmodule

// File: tb/tb_conv2_window_buf.sv
// Scoreboard bench for conv2_window_buf: a frame-array reference model pushes
// expected windows on each accepted pixel; a monitor pops them on each pulse.
module tb_conv2_window_buf;
  import conv2_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_in = 1'b0;
  logic [WIDTH-1:0] data_in1 = '0, data_in2 = '0, data_in3 = '0;
  logic [WIN_W-1:0] data_out1, data_out2, data_out3;
  logic             valid_out_buf, frame_done;

  conv2_window_buf dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .valid_out_buf(valid_out_buf), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIN_W-1:0] w1, w2, w3;
    logic             fd;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  int   n_win = 0, n_fd = 0;

  logic [WIDTH-1:0] f1 [IMG_H][IMG_W];
  logic [WIDTH-1:0] f2 [IMG_H][IMG_W];
  logic [WIDTH-1:0] f3 [IMG_H][IMG_W];
  int m_row = 0, m_col = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // A window at (row, col) covers rows row-K+1..row and cols col-K+1..col of the current frame.
  task automatic model_accept(input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                              input logic [WIDTH-1:0] d3);
    exp_t e;
    f1[m_row][m_col] = d1;
    f2[m_row][m_col] = d2;
    f3[m_row][m_col] = d3;
    if (m_row >= K-1 && m_col >= K-1) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) begin
          e.w1[(r*K+c)*WIDTH +: WIDTH] = f1[m_row-K+1+r][m_col-K+1+c];
          e.w2[(r*K+c)*WIDTH +: WIDTH] = f2[m_row-K+1+r][m_col-K+1+c];
          e.w3[(r*K+c)*WIDTH +: WIDTH] = f3[m_row-K+1+r][m_col-K+1+c];
        end
      e.fd  = (m_row == IMG_H-1 && m_col == IMG_W-1);
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    m_col++;
    if (m_col == IMG_W) begin
      m_col = 0;
      m_row = (m_row == IMG_H-1) ? 0 : m_row + 1;
    end
  endtask

  task automatic drive_px(input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                          input logic [WIDTH-1:0] d3);
    valid_in = 1'b1;
    data_in1 = d1;
    data_in2 = d2;
    data_in3 = d3;
    model_accept(d1, d2, d3);
  endtask

  task automatic send(input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                      input logic [WIDTH-1:0] d3, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      data_in1 = WIDTH'($urandom);
    end
    @(posedge clk); #1;
    drive_px(d1, d2, d3);
  endtask

  task automatic drain(input string nm, input int exp_win, input int exp_fd, input int win0, input int fd0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_queue_empty"}, WIN_W'(q.size()), '0);
    chk({nm, "_window_count"}, WIN_W'(n_win - win0), WIN_W'(exp_win));
    chk({nm, "_frame_done_count"}, WIN_W'(n_fd - fd0), WIN_W'(exp_fd));
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      if (frame_done && !valid_out_buf) chk("frame_done_without_window", WIN_W'(frame_done), '0);
      if (valid_out_buf) begin
        n_win++;
        if (frame_done) n_fd++;
        if (q.size() == 0) begin
          chk("unexpected_window", WIN_W'(valid_out_buf), '0);
        end else begin
          e = q.pop_front();
          chk("window_latency", WIN_W'(cyc), WIN_W'(e.cyc));
          chk("window_ch1", data_out1, e.w1);
          chk("window_ch2", data_out2, e.w2);
          chk("window_ch3", data_out3, e.w3);
          chk("frame_done", WIN_W'(frame_done), WIN_W'(e.fd));
        end
      end
    end
  end

  function automatic logic [WIDTH-1:0] el(input logic [WIN_W-1:0] w, input int k);
    return w[k*WIDTH +: WIDTH];
  endfunction

  initial begin
    int w0, d0;

    // Reset held: toggling valid_in must not disturb anything.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      valid_in = i[0];
      data_in1 = WIDTH'(i + 7);
      data_in2 = WIDTH'(i + 9);
      data_in3 = WIDTH'(i + 11);
    end
    @(posedge clk); #1;
    chk("rst_valid_out", WIN_W'(valid_out_buf), '0);
    chk("rst_frame_done", WIN_W'(frame_done), '0);
    chk("rst_data_out1", data_out1, '0);
    chk("rst_data_out2", data_out2, '0);
    chk("rst_data_out3", data_out3, '0);
    valid_in = 1'b0;
    #2 rst_n = 1'b1;

    // Continuous frame with spot checks at the first window and the row wrap.
    w0 = n_win; d0 = n_fd;
    for (int p = 0; p < IMG_W*IMG_H; p++) begin
      @(posedge clk); #1;
      if (p == 53) begin
        chk("first_valid", WIN_W'(valid_out_buf), WIN_W'(1));
        chk("first_ch1_e0", WIN_W'(el(data_out1, 0)), WIN_W'(0));
        chk("first_ch1_e4", WIN_W'(el(data_out1, 4)), WIN_W'(4));
        chk("first_ch1_e24", WIN_W'(el(data_out1, 24)), WIN_W'(52));
        chk("first_ch2_e24", WIN_W'(el(data_out2, 24)), WIN_W'(52 + 256));
        chk("first_ch3_e24", WIN_W'(el(data_out3, 24)), WIN_W'(12'hFCC));
      end
      if (p == 60) begin
        chk("wrap_p59_valid", WIN_W'(valid_out_buf), WIN_W'(1));
        chk("wrap_p59_e0", WIN_W'(el(data_out1, 0)), WIN_W'(7));
      end
      if (p >= 61 && p <= 64) chk("wrap_no_window", WIN_W'(valid_out_buf), '0);
      if (p == 65) begin
        chk("wrap_p64_valid", WIN_W'(valid_out_buf), WIN_W'(1));
        chk("wrap_p64_e0", WIN_W'(el(data_out1, 0)), WIN_W'(12));
        chk("wrap_p64_e24", WIN_W'(el(data_out1, 24)), WIN_W'(64));
      end
      drive_px(WIDTH'(p), WIDTH'(p + 256), WIDTH'(-p));
    end
    drain("frame_cont", 64, 1, w0, d0);

    // Same frame, one pixel every third cycle.
    w0 = n_win; d0 = n_fd;
    for (int p = 0; p < IMG_W*IMG_H; p++) send(WIDTH'(p), WIDTH'(p + 256), WIDTH'(-p), 2);
    drain("frame_gap3", 64, 1, w0, d0);

    // Two frames back to back; the second frame's windows must hold no first-frame data.
    w0 = n_win; d0 = n_fd;
    for (int p = 0; p < IMG_W*IMG_H; p++) send(WIDTH'(p), WIDTH'(p + 256), WIDTH'(-p), 0);
    for (int p = 0; p < IMG_W*IMG_H; p++) send(WIDTH'(1000 + p), WIDTH'(p + 256), WIDTH'(-p), 0);
    drain("frame_b2b", 128, 2, w0, d0);

    // Random data with random gaps.
    w0 = n_win; d0 = n_fd;
    for (int p = 0; p < 2*IMG_W*IMG_H; p++)
      send(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 2));
    drain("frame_rand", 128, 2, w0, d0);

    // Asynchronous reset after pixel 30, between clock edges.
    for (int p = 0; p <= 30; p++) send(WIDTH'(p + 1), WIDTH'(p + 2), WIDTH'(p + 3), 0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", WIN_W'(valid_out_buf), '0);
    chk("async_rst_data1", data_out1, '0);
    chk("async_rst_data3", data_out3, '0);
    chk("async_rst_queue", WIN_W'(q.size()), '0);
    q.delete();
    m_row = 0;
    m_col = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    w0 = n_win; d0 = n_fd;
    for (int p = 0; p < IMG_W*IMG_H; p++)
      send(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 0);
    drain("frame_after_rst", 64, 1, w0, d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
